// File: rtl/multi_debouncer.sv
// multi_debouncer
//
// Purpose:
//   Debounces CHANNELS independent, asynchronous, bouncy inputs. Each input
//   goes through a 2-flop synchronizer that runs on every fastClock edge. A
//   shared prescaler generates a sample tick every SAMPLE_DIV cycles. On each
//   tick, every channel shifts its synchronized level into a FILTER_WIDTH-bit
//   window, newest sample at bit 0. A window of all ones sets the debounced
//   level. A window of all zeros clears it. Any mix holds it.
//
// Parameters:
//   CHANNELS     - number of independent channels, 1..32
//   FILTER_WIDTH - consecutive equal samples needed to change a level, 2..16
//   SAMPLE_DIV   - fastClock cycles per sample tick, 1..65535
//   RESET_LEVEL  - level loaded into synchronizers, windows and outputs at reset
//
// Ports:
//   fastClock  in   1         only clock, rising edge
//   reset      in   1         synchronous, active-high
//   rawSignal  in   CHANNELS  asynchronous bouncy inputs
//   debounced  out  CHANNELS  filtered level per channel, registered
//   rise       out  CHANNELS  one-cycle pulse when debounced goes 0->1
//   fall       out  CHANNELS  one-cycle pulse when debounced goes 1->0
//   anyChange  out  1         OR of rise|fall over all channels, same cycle
//   sampleTick out  1         one-cycle pulse on each sample tick
//
// Configuration macro:
//   MULTI_DEBOUNCER_EDGE_EN - when defined, rise/fall/anyChange are generated.
//                             When undefined, those ports are tied to 0 and no
//                             edge-detect logic is built.

module multi_debouncer #(
  parameter int unsigned CHANNELS     = 4,
  parameter int unsigned FILTER_WIDTH = 3,
  parameter int unsigned SAMPLE_DIV   = 1,
  parameter bit          RESET_LEVEL  = 1'b0
) (
  input  logic                fastClock,
  input  logic                reset,
  input  logic [CHANNELS-1:0] rawSignal,
  output logic [CHANNELS-1:0] debounced,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic                anyChange,
  output logic                sampleTick
);

  // The counter needs at least one bit, even when SAMPLE_DIV is 1.
  localparam int unsigned CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SAMPLE_DIV - 1);

  localparam logic [CHANNELS-1:0]     CH_RESET  = {CHANNELS{RESET_LEVEL}};
  localparam logic [FILTER_WIDTH-1:0] WIN_RESET = {FILTER_WIDTH{RESET_LEVEL}};

  // Prescaler state
  logic [CNT_W-1:0] count_q, count_d;
  logic             tick;
  logic             sample_tick_q, sample_tick_d;

  // Synchronizer state
  logic [CHANNELS-1:0] sync1_q, sync1_d;
  logic [CHANNELS-1:0] sync2_q, sync2_d;

  // Filter state
  logic [CHANNELS-1:0][FILTER_WIDTH-1:0] window_q, window_d;
  logic [CHANNELS-1:0]                   debounced_q, debounced_d;

  // The prescaler wraps at SAMPLE_DIV-1. The tick is decoded from the current
  // count, so the window shift and the registered sampleTick land on the same
  // edge. The debounced change is therefore visible in the cycle sampleTick is high.
  always_comb begin
    tick          = (count_q == CNT_MAX);
    count_d       = tick ? '0 : count_q + CNT_W'(1);
    sample_tick_d = tick;
  end

  // Two-stage synchronizer. It runs every cycle, independent of the sample
  // tick, so the filter always sees a metastability-free level.
  always_comb begin
    sync1_d = rawSignal;
    sync2_d = sync1_q;
  end

  // On a tick, each channel shifts its synchronized level into the window.
  // The debounced level is decided from the window after the shift, so a level
  // held for FILTER_WIDTH samples updates the output on the edge that takes in
  // the last of those samples. Between ticks, everything holds.
  always_comb begin
    window_d    = window_q;
    debounced_d = debounced_q;
    if (tick) begin
      for (int ch = 0; ch < CHANNELS; ch++) begin
        window_d[ch] = {window_q[ch][FILTER_WIDTH-2:0], sync2_q[ch]};
        if (&window_d[ch]) begin
          debounced_d[ch] = 1'b1;
        end else if (~|window_d[ch]) begin
          debounced_d[ch] = 1'b0;
        end
      end
    end
  end

  // Core state registers. Reset discards the partial windows and the
  // prescaler phase, and reloads every level with RESET_LEVEL.
  always_ff @(posedge fastClock) begin
    if (reset) begin
      count_q       <= '0;
      sample_tick_q <= 1'b0;
      sync1_q       <= CH_RESET;
      sync2_q       <= CH_RESET;
      for (int ch = 0; ch < CHANNELS; ch++) begin
        window_q[ch] <= WIN_RESET;
      end
      debounced_q   <= CH_RESET;
    end else begin
      count_q       <= count_d;
      sample_tick_q <= sample_tick_d;
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      window_q      <= window_d;
      debounced_q   <= debounced_d;
    end
  end

  assign debounced  = debounced_q;
  assign sampleTick = sample_tick_q;

`ifdef MULTI_DEBOUNCER_EDGE_EN
  // Edge pulse state
  logic [CHANNELS-1:0] rise_q, rise_d;
  logic [CHANNELS-1:0] fall_q, fall_d;
  logic                any_change_q, any_change_d;

  // The pulses compare the next debounced value with the current one. They
  // are registered next to debounced_q, so each pulse appears in the same
  // cycle as the level change and lasts exactly one cycle. The edge registers
  // are cleared along with the level on reset. A reset-induced level jump
  // therefore never produces a pulse.
  always_comb begin
    rise_d       = debounced_d & ~debounced_q;
    fall_d       = ~debounced_d & debounced_q;
    any_change_d = |(rise_d | fall_d);
  end

  // Edge pulse registers
  always_ff @(posedge fastClock) begin
    if (reset) begin
      rise_q       <= '0;
      fall_q       <= '0;
      any_change_q <= 1'b0;
    end else begin
      rise_q       <= rise_d;
      fall_q       <= fall_d;
      any_change_q <= any_change_d;
    end
  end

  assign rise      = rise_q;
  assign fall      = fall_q;
  assign anyChange = any_change_q;
`else
  // Edge detection is not built; the ports remain and read as 0.
  assign rise      = '0;
  assign fall      = '0;
  assign anyChange = 1'b0;
`endif

endmodule

// File: tb/tb_multi_debouncer.sv
// tb_multi_debouncer
//
// Directed testbench for multi_debouncer. It uses three instances:
//   A: FILTER_WIDTH=3, SAMPLE_DIV=1, RESET_LEVEL=0
//   B: FILTER_WIDTH=4, SAMPLE_DIV=5, RESET_LEVEL=0
//   C: FILTER_WIDTH=3, SAMPLE_DIV=3, RESET_LEVEL=1
// The expected pulse values follow the MULTI_DEBOUNCER_EDGE_EN setting of the
// build. When that macro is undefined, rise/fall/anyChange must stay 0.

module tb_multi_debouncer;

`ifdef MULTI_DEBOUNCER_EDGE_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  logic fastClock = 1'b0;
  int   compared   = 0;
  int   mismatched = 0;

  logic       resetA, resetB, resetC;
  logic [3:0] rawA, rawB, rawC;
  logic [3:0] debA, riseA, fallA;
  logic [3:0] debB, riseB, fallB;
  logic [3:0] debC, riseC, fallC;
  logic       anyA, anyB, anyC;
  logic       tickA, tickB, tickC;

  always #5 fastClock = ~fastClock;

  multi_debouncer #(.CHANNELS(4), .FILTER_WIDTH(3), .SAMPLE_DIV(1), .RESET_LEVEL(1'b0)) dutA (
    .fastClock(fastClock), .reset(resetA), .rawSignal(rawA), .debounced(debA),
    .rise(riseA), .fall(fallA), .anyChange(anyA), .sampleTick(tickA));

  multi_debouncer #(.CHANNELS(4), .FILTER_WIDTH(4), .SAMPLE_DIV(5), .RESET_LEVEL(1'b0)) dutB (
    .fastClock(fastClock), .reset(resetB), .rawSignal(rawB), .debounced(debB),
    .rise(riseB), .fall(fallB), .anyChange(anyB), .sampleTick(tickB));

  multi_debouncer #(.CHANNELS(4), .FILTER_WIDTH(3), .SAMPLE_DIV(3), .RESET_LEVEL(1'b1)) dutC (
    .fastClock(fastClock), .reset(resetC), .rawSignal(rawC), .debounced(debC),
    .rise(riseC), .fall(fallC), .anyChange(anyC), .sampleTick(tickC));

  // Advance to just after the next rising edge, where outputs are stable.
  task automatic step();
    @(posedge fastClock);
    #1;
  endtask

  // Reset state of all three instances; C stays in reset for its own test.
  task automatic test_reset();
    resetA = 1'b1; resetB = 1'b1; resetC = 1'b1;
    rawA = 4'b0000; rawB = 4'b0000; rawC = 4'b0000;
    step();
    step();
    compared++; if (debA !== 4'b0000) begin mismatched++; $display("[TB] FAIL reset_debA: got %b expected %b", debA, 4'b0000); end
    compared++; if (riseA !== 4'b0000) begin mismatched++; $display("[TB] FAIL reset_riseA: got %b expected %b", riseA, 4'b0000); end
    compared++; if (fallA !== 4'b0000) begin mismatched++; $display("[TB] FAIL reset_fallA: got %b expected %b", fallA, 4'b0000); end
    compared++; if (anyA !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_anyA: got %b expected %b", anyA, 1'b0); end
    compared++; if (tickA !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_tickA: got %b expected %b", tickA, 1'b0); end
    compared++; if (debB !== 4'b0000) begin mismatched++; $display("[TB] FAIL reset_debB: got %b expected %b", debB, 4'b0000); end
    compared++; if (tickB !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_tickB: got %b expected %b", tickB, 1'b0); end
    compared++; if (debC !== 4'b1111) begin mismatched++; $display("[TB] FAIL reset_debC: got %b expected %b", debC, 4'b1111); end
    compared++; if (fallC !== 4'b0000) begin mismatched++; $display("[TB] FAIL reset_fallC: got %b expected %b", fallC, 4'b0000); end
    compared++; if (tickC !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_tickC: got %b expected %b", tickC, 1'b0); end
    resetA = 1'b0;
    resetB = 1'b0;
    repeat (4) step();
  endtask

  // Channel 0 rises and holds on A; the level appears four edges later.
  task automatic test_rise_hold();
    rawA = 4'b0001;
    for (int k = 0; k <= 6; k++) begin
      logic [3:0] expD, expR;
      logic       expAny;
      step();
      expD   = (k >= 4) ? 4'b0001 : 4'b0000;
      expR   = (EDGE_EN && k == 4) ? 4'b0001 : 4'b0000;
      expAny = EDGE_EN && (k == 4);
      compared++; if (debA !== expD) begin mismatched++; $display("[TB] FAIL rise_hold_deb k=%0d: got %b expected %b", k, debA, expD); end
      compared++; if (riseA !== expR) begin mismatched++; $display("[TB] FAIL rise_hold_rise k=%0d: got %b expected %b", k, riseA, expR); end
      compared++; if (fallA !== 4'b0000) begin mismatched++; $display("[TB] FAIL rise_hold_fall k=%0d: got %b expected %b", k, fallA, 4'b0000); end
      compared++; if (anyA !== expAny) begin mismatched++; $display("[TB] FAIL rise_hold_any k=%0d: got %b expected %b", k, anyA, expAny); end
      compared++; if (tickA !== 1'b1) begin mismatched++; $display("[TB] FAIL rise_hold_tick k=%0d: got %b expected %b", k, tickA, 1'b1); end
    end
  endtask

  // A two-cycle pulse on channel 1 is too short to pass the filter.
  task automatic test_glitch();
    rawA = 4'b0011;
    for (int k = 0; k <= 9; k++) begin
      step();
      compared++; if (debA !== 4'b0001) begin mismatched++; $display("[TB] FAIL glitch_deb k=%0d: got %b expected %b", k, debA, 4'b0001); end
      compared++; if (riseA !== 4'b0000) begin mismatched++; $display("[TB] FAIL glitch_rise k=%0d: got %b expected %b", k, riseA, 4'b0000); end
      compared++; if (anyA !== 1'b0) begin mismatched++; $display("[TB] FAIL glitch_any k=%0d: got %b expected %b", k, anyA, 1'b0); end
      if (k == 1) rawA = 4'b0001;
    end
  endtask

  // Channel 0 falls back to 0 on A.
  task automatic test_fall();
    rawA = 4'b0000;
    for (int k = 0; k <= 6; k++) begin
      logic [3:0] expD, expF;
      logic       expAny;
      step();
      expD   = (k >= 4) ? 4'b0000 : 4'b0001;
      expF   = (EDGE_EN && k == 4) ? 4'b0001 : 4'b0000;
      expAny = EDGE_EN && (k == 4);
      compared++; if (debA !== expD) begin mismatched++; $display("[TB] FAIL fall_deb k=%0d: got %b expected %b", k, debA, expD); end
      compared++; if (fallA !== expF) begin mismatched++; $display("[TB] FAIL fall_fall k=%0d: got %b expected %b", k, fallA, expF); end
      compared++; if (riseA !== 4'b0000) begin mismatched++; $display("[TB] FAIL fall_rise k=%0d: got %b expected %b", k, riseA, 4'b0000); end
      compared++; if (anyA !== expAny) begin mismatched++; $display("[TB] FAIL fall_any k=%0d: got %b expected %b", k, anyA, expAny); end
    end
  endtask

  // All four channels on A rise on the same edge.
  task automatic test_simultaneous();
    rawA = 4'b1111;
    for (int k = 0; k <= 6; k++) begin
      logic [3:0] expD, expR;
      logic       expAny;
      step();
      expD   = (k >= 4) ? 4'b1111 : 4'b0000;
      expR   = (EDGE_EN && k == 4) ? 4'b1111 : 4'b0000;
      expAny = EDGE_EN && (k == 4);
      compared++; if (debA !== expD) begin mismatched++; $display("[TB] FAIL simul_deb k=%0d: got %b expected %b", k, debA, expD); end
      compared++; if (riseA !== expR) begin mismatched++; $display("[TB] FAIL simul_rise k=%0d: got %b expected %b", k, riseA, expR); end
      compared++; if (anyA !== expAny) begin mismatched++; $display("[TB] FAIL simul_any k=%0d: got %b expected %b", k, anyA, expAny); end
    end
  endtask

  // On B (window 4, divide 5), channel 2 rises and then falls.
  // Ticks come at n = 5, 10, 15, ... after reset release.
  // The rise completes at n=20. The drop is driven after n=22 and is
  // synchronized by n=24, so it is sampled at n=25, 30, 35 and 40.
  task automatic test_prescaler_fall();
    resetB = 1'b1;
    rawB   = 4'b0100;
    step();
    resetB = 1'b0;
    for (int n = 1; n <= 42; n++) begin
      logic [3:0] expD, expR, expF;
      logic       expTick, expAny;
      step();
      expTick = (n % 5 == 0);
      expD    = (n >= 20 && n < 40) ? 4'b0100 : 4'b0000;
      expR    = (EDGE_EN && n == 20) ? 4'b0100 : 4'b0000;
      expF    = (EDGE_EN && n == 40) ? 4'b0100 : 4'b0000;
      expAny  = EDGE_EN && (n == 20 || n == 40);
      compared++; if (tickB !== expTick) begin mismatched++; $display("[TB] FAIL div_tick n=%0d: got %b expected %b", n, tickB, expTick); end
      compared++; if (debB !== expD) begin mismatched++; $display("[TB] FAIL div_deb n=%0d: got %b expected %b", n, debB, expD); end
      compared++; if (riseB !== expR) begin mismatched++; $display("[TB] FAIL div_rise n=%0d: got %b expected %b", n, riseB, expR); end
      compared++; if (fallB !== expF) begin mismatched++; $display("[TB] FAIL div_fall n=%0d: got %b expected %b", n, fallB, expF); end
      compared++; if (anyB !== expAny) begin mismatched++; $display("[TB] FAIL div_any n=%0d: got %b expected %b", n, anyB, expAny); end
      if (n == 22) rawB = 4'b0000;
    end
  endtask

  // On C (reset level 1, divide 3), the low input has been sampled twice when
  // reset is applied again. The reset must reload ones without a fall pulse.
  // The prescaler restarts, so the full low window completes 9 cycles later.
  task automatic test_reset_midwindow();
    rawC   = 4'b0000;
    resetC = 1'b0;
    for (int n = 1; n <= 7; n++) begin
      step();
      compared++; if (debC !== 4'b1111) begin mismatched++; $display("[TB] FAIL mid_pre_deb n=%0d: got %b expected %b", n, debC, 4'b1111); end
      compared++; if (tickC !== (n % 3 == 0)) begin mismatched++; $display("[TB] FAIL mid_pre_tick n=%0d: got %b expected %b", n, tickC, (n % 3 == 0)); end
      compared++; if (fallC !== 4'b0000) begin mismatched++; $display("[TB] FAIL mid_pre_fall n=%0d: got %b expected %b", n, fallC, 4'b0000); end
    end
    resetC = 1'b1;
    step();
    compared++; if (debC !== 4'b1111) begin mismatched++; $display("[TB] FAIL mid_rst_deb: got %b expected %b", debC, 4'b1111); end
    compared++; if (fallC !== 4'b0000) begin mismatched++; $display("[TB] FAIL mid_rst_fall: got %b expected %b", fallC, 4'b0000); end
    compared++; if (anyC !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_rst_any: got %b expected %b", anyC, 1'b0); end
    compared++; if (tickC !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_rst_tick: got %b expected %b", tickC, 1'b0); end
    resetC = 1'b0;
    for (int m = 1; m <= 10; m++) begin
      logic [3:0] expD, expF;
      logic       expAny;
      step();
      expD   = (m >= 9) ? 4'b0000 : 4'b1111;
      expF   = (EDGE_EN && m == 9) ? 4'b1111 : 4'b0000;
      expAny = EDGE_EN && (m == 9);
      compared++; if (tickC !== (m % 3 == 0)) begin mismatched++; $display("[TB] FAIL mid_post_tick m=%0d: got %b expected %b", m, tickC, (m % 3 == 0)); end
      compared++; if (debC !== expD) begin mismatched++; $display("[TB] FAIL mid_post_deb m=%0d: got %b expected %b", m, debC, expD); end
      compared++; if (fallC !== expF) begin mismatched++; $display("[TB] FAIL mid_post_fall m=%0d: got %b expected %b", m, fallC, expF); end
      compared++; if (anyC !== expAny) begin mismatched++; $display("[TB] FAIL mid_post_any m=%0d: got %b expected %b", m, anyC, expAny); end
    end
  endtask

  // Run the scenarios in order. Each scenario starts from the state the
  // previous one left behind.
  initial begin
    $display("[TB] multi_debouncer bench, edge detection %0s", EDGE_EN ? "enabled" : "disabled");
    test_reset();
    test_rise_hold();
    test_glitch();
    test_fall();
    test_simultaneous();
    test_prescaler_fall();
    test_reset_midwindow();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/multi_debouncer.md
MULTI_DEBOUNCER -- requirements
Module: multi_debouncer

Interface
REQ-001 SHALL have parameter CHANNELS, default 4: number of independent input channels, 1..32.
REQ-002 SHALL have parameter FILTER_WIDTH, default 3: consecutive equal samples needed to change output, 2..16.
REQ-003 SHALL have parameter SAMPLE_DIV, default 1: fastClock cycles per sample tick, 1..65535.
REQ-004 SHALL have parameter RESET_LEVEL, default 0: level loaded into all state and debounced outputs at reset.
REQ-005 SHALL have port fastClock, input, 1: the only clock, rising-edge.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port rawSignal, input, CHANNELS: asynchronous, bouncy inputs.
REQ-008 SHALL have port debounced, output, CHANNELS: filtered level per channel, registered.
REQ-009 SHALL have port rise, output, CHANNELS: one-cycle pulse on a debounced 0->1 change.
REQ-010 SHALL have port fall, output, CHANNELS: one-cycle pulse on a debounced 1->0 change.
REQ-011 SHALL have port anyChange, output, 1: registered OR of rise|fall over all channels, same cycle as the pulses.
REQ-012 SHALL have port sampleTick, output, 1: high for one cycle on each sample tick.

Function
REQ-013 Each channel SHALL pass rawSignal through a 2-flop synchronizer, clocked every fastClock cycle, independent of sampleTick.
REQ-014 Prescaler SHALL count 0..SAMPLE_DIV-1 and wrap; sampleTick SHALL be high when count == SAMPLE_DIV-1. With SAMPLE_DIV=1 it SHALL be high every cycle after reset.
REQ-015 On a tick, each channel SHALL shift its synchronizer output into a FILTER_WIDTH-bit window, newest at bit 0.
REQ-016 On the same tick, the new window all ones SHALL set debounced to 1; all zeros SHALL clear it; any mix SHALL hold it.
REQ-017 With SAMPLE_DIV=1, a level held from fastClock edge E0 on SHALL appear on debounced at edge E0+FILTER_WIDTH+1.
REQ-018 An excursion shorter than FILTER_WIDTH consecutive samples SHALL NOT change debounced.
REQ-019 Between ticks, window and debounced SHALL hold.
REQ-020 rise/fall SHALL be asserted in the same cycle debounced changes, for exactly one cycle, otherwise 0; they SHALL never both be high for one channel.
REQ-021 Channels SHALL be fully independent; simultaneous changes on several channels SHALL produce simultaneous pulses.
REQ-022 Window comparison SHALL use the full FILTER_WIDTH for every legal value, with no fixed-width constants.

Reset
REQ-023 While reset is high at a rising edge, synchronizers, windows and debounced SHALL load RESET_LEVEL; rise, fall, anyChange, sampleTick and prescaler SHALL load 0.
REQ-024 Reset asserted mid-operation SHALL discard partial windows and prescaler count, with no edge pulse from the reset itself.
REQ-025 After reset deasserts, the first tick SHALL occur SAMPLE_DIV cycles later.

Configuration
REQ-026 Macro MULTI_DEBOUNCER_EDGE_EN defined: rise, fall and anyChange SHALL be generated as in REQ-011 and REQ-020.
REQ-027 Macro MULTI_DEBOUNCER_EDGE_EN undefined: ports SHALL remain, tied to constant 0, with no edge-detect logic; all other behaviour SHALL be unchanged.

Verification
REQ-028 FW=3, DIV=1, RESET_LEVEL=0: ch0 0->1 held from E0 -> debounced[0]=1 and rise[0]=1 at E4, rise[0]=0 at E5, anyChange=1 at E4 only.
REQ-029 FW=3, DIV=1: ch1 high for 2 cycles then low -> debounced[1] stays 0, no pulses.
REQ-030 FW=4, DIV=5: ch2 1->0 held -> fall[2] coincides with the 4th sampleTick at which the synchronized low is sampled; sampleTick period 5 cycles.
REQ-031 CHANNELS=4, all inputs 0->1 on one edge -> rise=4'b1111 in one cycle, anyChange=1.
REQ-032 RESET_LEVEL=1, reset asserted 2 cycles into a stable-low window -> debounced=all ones, no fall pulse, prescaler restarts at 0.
REQ-033 MULTI_DEBOUNCER_EDGE_EN undefined, repeat REQ-028 -> debounced identical, rise/fall/anyChange constantly 0.
